ic_skolem_urem_search: RTL and testbench



---
 rtl/ic_skolem_pkg.sv | 55 +++++
 rtl/ic_serial_urem.sv | 80 ++++++++
 rtl/ic_skolem_urem_search.sv | 169 ++++++++++++++++
 tb/tb_ic_skolem_urem_search.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ic_skolem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ic_skolem_pkg
// Desc     : Shared definitions for the urem witness search: comparison mode
//            codes, search FSM state encoding and the comparison helper.
// Revision : 1.0 - initial release
// ============================================================================
package ic_skolem_pkg;

    // Comparison modes for "x urem s CMP t"
    localparam int CMP_SGE = 0;
    localparam int CMP_SGT = 1;
    localparam int CMP_UGE = 2;
    localparam int CMP_UGT = 3;

    // Widest operand the comparison helper handles
    localparam int c_MAX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Operands arrive zero-extended to c_MAX_W. Signed modes flip the sign
    // bit (bit width-1) of both sides so a plain unsigned compare orders
    // them as two's-complement values.
    function automatic logic cmp_pass(input logic [c_MAX_W-1:0] rem,
                                      input logic [c_MAX_W-1:0] t,
                                      input int                 mode,
                                      input int                 width);
        logic [c_MAX_W-1:0] w_sgn;
        logic [c_MAX_W-1:0] w_a;
        logic [c_MAX_W-1:0] w_b;
        logic               w_res;
        w_sgn = c_MAX_W'(1) << (width - 1);
        if (mode == CMP_SGE || mode == CMP_SGT) begin
            w_a = rem ^ w_sgn;
            w_b = t ^ w_sgn;
        end else begin
            w_a = rem;
            w_b = t;
        end
        if (mode == CMP_SGE || mode == CMP_UGE) begin
            w_res = (w_a >= w_b);
        end else begin
            w_res = (w_a > w_b);
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ic_serial_urem.sv
`default_nettype none
// ============================================================================
// Module   : ic_serial_urem
// Desc     : Restoring serial unsigned remainder, one quotient bit per cycle,
//            MSB first. done pulses in the cycle rem holds the final result.
//            A zero divisor returns the dividend one cycle after start.
// Revision : 1.0 - initial release
// ============================================================================
module ic_serial_urem #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] rem
);

    localparam int c_CNT_W = $clog2(W + 1);

    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_dvd;
    logic [W-1:0]       r_dvs;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    // Shifted partial remainder is W+1 bits; the stored remainder is always
    // below the divisor, so it fits in W bits between steps.
    logic [W:0] w_trial;
    logic [W:0] w_diff;
    logic       w_ge;

    assign w_trial = {r_rem, r_dvd[W-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    // trial < 2*divisor, so a negative difference always sets bit W
    assign w_ge    = ~w_diff[W];

    // Load on start, then one restoring step per cycle for W cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_dvd <= dividend;
                r_dvs <= divisor;
                r_cnt <= c_CNT_W'(W);
                if (divisor == '0) begin
                    r_rem  <= dividend;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_rem  <= '0;
                    r_busy <= 1'b1;
                end
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
                r_dvd <= {r_dvd[W-2:0], w_ge};
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign rem  = r_rem;

endmodule
`default_nettype wire

// File: rtl/ic_skolem_urem_search.sv
`default_nettype none
// ============================================================================
// Module   : ic_skolem_urem_search
// Desc     : Sequential witness search for "x urem s CMP t". Sweeps x from 0
//            to 2^W-1 through a serial divider and returns the first passing
//            x, or found=0 when none exists.
// Config   : IC_SKOLEM_HINT_EN - test x=t and x=~(-s) before the sweep.
// Revision : 1.0 - initial release
// ============================================================================
module ic_skolem_urem_search
    import ic_skolem_pkg::*;
#(
    parameter int W   = 4,
    parameter int CMP = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_s,
    input  logic [W-1:0] req_t,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_found,
    output logic [W-1:0] resp_x,
    output logic [W:0]   resp_evals
);

    localparam int                c_STEP_W    = $clog2(W + 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(W - 1);

    state_t              r_state;
    logic [W-1:0]        r_s;
    logic [W-1:0]        r_t;
    logic [W-1:0]        r_x;
    logic [W:0]          r_evals;
    logic [c_STEP_W-1:0] r_step;
    logic                r_resp_valid;
    logic                r_found;
    logic [W-1:0]        r_resp_x;
    logic [W:0]          r_resp_evals;

`ifdef IC_SKOLEM_HINT_EN
    localparam logic [1:0] c_PH_T     = 2'd0;
    localparam logic [1:0] c_PH_S     = 2'd1;
    localparam logic [1:0] c_PH_SWEEP = 2'd2;
    logic [1:0] r_phase;
`endif

    logic         w_accept;
    logic         w_div_done;
    logic [W-1:0] w_rem;
    logic         w_pass;
    logic         w_last;
    logic [W:0]   w_evals_inc;

    assign req_ready   = (r_state == ST_IDLE) & ~r_resp_valid;
    assign w_accept    = req_valid & req_ready;
    assign w_pass      = cmp_pass(c_MAX_W'(w_rem), c_MAX_W'(r_t), CMP, W);
    assign w_evals_inc = r_evals + (W+1)'(1);
`ifdef IC_SKOLEM_HINT_EN
    assign w_last      = (r_phase == c_PH_SWEEP) & (&r_x);
`else
    assign w_last      = &r_x;
`endif

    ic_serial_urem #(.W(W)) u_urem (
        .clk      (clk),
        .rst      (rst),
        .start    (r_state == ST_LOAD),
        .dividend (r_x),
        .divisor  (r_s),
        .done     (w_div_done),
        .rem      (w_rem)
    );

    // Search sequencing: accept, evaluate candidates, hold response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_t          <= '0;
            r_x          <= '0;
            r_evals      <= '0;
            r_step       <= '0;
            r_resp_valid <= 1'b0;
            r_found      <= 1'b0;
            r_resp_x     <= '0;
            r_resp_evals <= '0;
`ifdef IC_SKOLEM_HINT_EN
            r_phase      <= c_PH_SWEEP;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_s     <= req_s;
                        r_t     <= req_t;
                        r_evals <= '0;
`ifdef IC_SKOLEM_HINT_EN
                        r_x     <= req_t;
                        r_phase <= c_PH_T;
`else
                        r_x     <= '0;
`endif
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_step  <= '0;
                    r_state <= (r_s == '0) ? ST_CHECK : ST_DIV;
                end
                ST_DIV: begin
                    r_step <= r_step + c_STEP_W'(1);
                    if (r_step == c_STEP_LAST) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_div_done) begin
                        r_evals <= w_evals_inc;
                        if (w_pass) begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                            r_found      <= 1'b1;
                            r_resp_x     <= r_x;
                            r_resp_evals <= w_evals_inc;
                        end else if (w_last) begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                            r_found      <= 1'b0;
                            r_resp_x     <= '0;
                            r_resp_evals <= w_evals_inc;
                        end else begin
`ifdef IC_SKOLEM_HINT_EN
                            if (r_phase == c_PH_T) begin
                                r_x     <= ~(-r_s);
                                r_phase <= c_PH_S;
                            end else if (r_phase == c_PH_S) begin
                                r_x     <= '0;
                                r_phase <= c_PH_SWEEP;
                            end else begin
                                r_x <= r_x + W'(1);
                            end
`else
                            r_x <= r_x + W'(1);
`endif
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_found = r_found;
    assign resp_x     = r_resp_x;
    assign resp_evals = r_resp_evals;

endmodule
`default_nettype wire

// File: tb/tb_ic_skolem_urem_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_ic_skolem_urem_search
// Desc     : Self-checking bench: one instance per comparison mode, results
//            compared against a candidate-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ic_skolem_urem_search;

    localparam int W    = 4;
    localparam int NI   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid  [NI];
    logic         req_ready  [NI];
    logic [W-1:0] req_s      [NI];
    logic [W-1:0] req_t      [NI];
    logic         resp_valid [NI];
    logic         resp_ready [NI];
    logic         resp_found [NI];
    logic [W-1:0] resp_x     [NI];
    logic [W:0]   resp_evals [NI];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    bit rem_bad = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            ic_skolem_urem_search #(.W(W), .CMP(g)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_s      (req_s[g]),
                .req_t      (req_t[g]),
                .resp_valid (resp_valid[g]),
                .resp_ready (resp_ready[g]),
                .resp_found (resp_found[g]),
                .resp_x     (resp_x[g]),
                .resp_evals (resp_evals[g])
            );
        end
    endgenerate

    // Remainder bound watch for the s=3 sweep
    always @(negedge clk) begin
        if (mon_en && (g_dut[0].u_dut.u_urem.rem > 4'd2)) rem_bad = 1'b1;
    end

    function automatic int to_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic bit passes(input int r, input int t, input int mode);
        case (mode)
            0:       return to_signed(r) >= to_signed(t);
            1:       return to_signed(r) >  to_signed(t);
            2:       return r >= t;
            default: return r >  t;
        endcase
    endfunction

    // Reference: walk the candidate list in order with plain arithmetic
    function automatic void model(input int mode, input int s, input int t,
                                  output int found, output int x,
                                  output int evals, output int lat);
        int cand[$];
`ifdef IC_SKOLEM_HINT_EN
        cand.push_back(t);
        cand.push_back((s - 1) & MAXV);
`endif
        for (int i = 0; i <= MAXV; i++) cand.push_back(i);
        found = 0; x = 0; evals = 0; lat = 0;
        foreach (cand[i]) begin
            int c;
            int r;
            c = cand[i];
            r = (s == 0) ? c : c % s;
            evals++;
            lat += (s == 0) ? 2 : W + 2;
            if (passes(r, t, mode)) begin
                found = 1;
                x = c;
                return;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input int k, input int s, input int t);
        int waited;
        waited = 0;
        while (!req_ready[k] && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_req", 32'(req_ready[k]), 1);
        req_s[k]     = W'(s);
        req_t[k]     = W'(t);
        req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        check("busy_after_accept", 32'(req_ready[k]), 0);
    endtask

    task automatic collect(input int k, input int s, input int t, input bit mon);
        int ef, ex, ee, el, lat;
        model(k, s, t, ef, ex, ee, el);
        lat = -1;
        for (int n = 1; n <= (MAXV + 3) * (W + 2) + 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) mon_en = mon;
            if (resp_valid[k]) begin
                lat = n;
                break;
            end
        end
        mon_en = 1'b0;
        check("latency", 32'(lat), 32'(el));
        check("found",   32'(resp_found[k]), 32'(ef));
        check("x",       32'(resp_x[k]), 32'(ex));
        check("evals",   32'(resp_evals[k]), 32'(ee));
    endtask

    task automatic drop(input int k);
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        check("dropped",          32'(resp_valid[k]), 0);
        check("ready_after_drop", 32'(req_ready[k]), 1);
    endtask

    task automatic run(input int k, input int s, input int t, input bit mon);
        issue(k, s, t);
        collect(k, s, t, mon);
        drop(k);
    endtask

    task automatic check_reset_state(input int k);
        check("rst_req_ready",  32'(req_ready[k]), 1);
        check("rst_resp_valid", 32'(resp_valid[k]), 0);
        check("rst_resp_found", 32'(resp_found[k]), 0);
        check("rst_resp_x",     32'(resp_x[k]), 0);
        check("rst_resp_evals", 32'(resp_evals[k]), 0);
    endtask

    initial begin
        int ef, ex, ee, el;
        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            req_s[i]      = '0;
            req_t[i]      = '0;
            resp_ready[i] = 1'b0;
        end

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state(0);

        // Directed cases
        run(0, 3, 2, 1'b0);
        rem_bad = 1'b0;
        run(0, 3, 7, 1'b1);
        check("rem_le_2", 32'(rem_bad), 0);
        run(0, 0, 7, 1'b0);
        run(3, 5, 15, 1'b0);
        run(2, 5, 0, 1'b0);
        run(0, 1, 0, 1'b0);
        run(3, 1, 0, 1'b0);
        run(1, 0, 15, 1'b0);

        // Backpressure: response held, requests ignored meanwhile
        model(0, 3, 2, ef, ex, ee, el);
        issue(0, 3, 2);
        collect(0, 3, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            req_valid[0] = 1'b1;
            req_s[0]     = W'($urandom);
            req_t[0]     = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid", 32'(resp_valid[0]), 1);
            check("bp_x",     32'(resp_x[0]), 32'(ex));
            check("bp_evals", 32'(resp_evals[0]), 32'(ee));
            check("bp_ready", 32'(req_ready[0]), 0);
        end
        req_valid[0] = 1'b0;
        drop(0);
        issue(0, 0, 7);
        collect(0, 0, 7, 1'b0);
        drop(0);

        // Reset during DIV of the 5th candidate
        issue(0, 3, 7);
        repeat (26) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state(0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(resp_valid[0]), 0);
        check("post_rst_ready", 32'(req_ready[0]), 1);
        run(0, 3, 2, 1'b0);

        // Randomised requests across all modes
        for (int i = 0; i < 24; i++) begin
            int k, s, t;
            k = int'($urandom_range(0, NI - 1));
            s = int'($urandom_range(0, MAXV));
            t = int'($urandom_range(0, MAXV));
            run(k, s, t, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
